// File: rtl/lsu_arb_pkg.sv
// Shared types for the dual-slot LSU arbiter.
package lsu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } state_t;

   typedef struct packed {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic        slot;
   } mem_op_t;

   localparam logic SLOT1 = 1'b0;
   localparam logic SLOT2 = 1'b1;

endpackage

// File: rtl/lsu_op_slot.sv
// Single mem-op holding register with valid bit; clear wins over load.
module lsu_op_slot
   import lsu_arb_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    load,
   input  logic    clear,
   input  mem_op_t op_in,
   output mem_op_t op_q,
   output logic    valid_q
);

   // Capture an op on load, drop it on clear or reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q    <= '0;
         valid_q <= 1'b0;
      end else if (clear) begin
         valid_q <= 1'b0;
      end else if (load) begin
         op_q    <= op_in;
         valid_q <= 1'b1;
      end
   end

endmodule

// File: rtl/lsu_arbiter.sv
// Arbitrates two decode slots onto a single LSU port, oldest slot first.
module lsu_arbiter
   import lsu_arb_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req1,
   input  logic        req2,
   input  logic        we1,
   input  logic        we2,
   input  logic [2:0]  f3_1,
   input  logic [2:0]  f3_2,
   input  logic [31:0] addr1,
   input  logic [31:0] addr2,
   input  logic [31:0] wdata1,
   input  logic [31:0] wdata2,
   input  logic [4:0]  rd1,
   input  logic [4:0]  rd2,
   input  logic        flush,
   input  logic        lsu_done,
   input  logic [31:0] lsu_rdata,
   output logic        accept1,
   output logic        accept2,
   output logic        stall,
   output logic        lsu_start,
   output logic [31:0] lsu_addr,
   output logic [31:0] lsu_wdata,
   output logic        lsu_we,
   output logic [2:0]  lsu_f3,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        wb_slot
);

   state_t  state, next_state;
   mem_op_t op1, op2;
   mem_op_t cur_op, cur_next;
   mem_op_t pend_op;
   logic    pend_v;
   logic    cur_load, pend_load, pend_clear, wb_fire;

   assign op1 = '{we: we1, f3: f3_1, addr: addr1, wdata: wdata1, rd: rd1, slot: SLOT1};
   assign op2 = '{we: we2, f3: f3_2, addr: addr2, wdata: wdata2, rd: rd2, slot: SLOT2};

   assign accept1 = req1 && (state == IDLE) && !flush;
   assign accept2 = req2 && (state == IDLE) && !flush;

   assign lsu_addr  = cur_op.addr;
   assign lsu_wdata = cur_op.wdata;
   assign lsu_we    = cur_op.we;
   assign lsu_f3    = cur_op.f3;

   lsu_op_slot u_pend (
      .clk     (clk),
      .rst     (rst),
      .load    (pend_load),
      .clear   (pend_clear),
      .op_in   (op2),
      .op_q    (pend_op),
      .valid_q (pend_v)
   );

   // Next-state and datapath control; flush only ever cancels the pending op.
   always_comb begin
      next_state = state;
      cur_load   = 1'b0;
      cur_next   = cur_op;
      pend_load  = 1'b0;
      pend_clear = 1'b0;
      wb_fire    = 1'b0;
      case (state)
         IDLE: begin
            if (accept1) begin
               cur_load   = 1'b1;
               cur_next   = op1;
               next_state = START;
               pend_load  = accept2;
            end else if (accept2) begin
               cur_load   = 1'b1;
               cur_next   = op2;
               next_state = START;
            end
         end
         START: begin
            next_state = WAIT;
            pend_clear = flush;
         end
         WAIT: begin
            pend_clear = flush;
            if (lsu_done) begin
               wb_fire    = !cur_op.we;
               pend_clear = 1'b1;
               if (pend_v && !flush) begin
                  cur_load   = 1'b1;
                  cur_next   = pend_op;
                  next_state = START;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // State, LSU-facing op register, start pulse, stall and writeback registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cur_op    <= '0;
         lsu_start <= 1'b0;
         stall     <= 1'b0;
         wb_valid  <= 1'b0;
         wb_rd     <= '0;
         wb_data   <= '0;
         wb_slot   <= 1'b0;
      end else begin
         state     <= next_state;
         lsu_start <= (next_state == START);
         stall     <= (next_state != IDLE);
         wb_valid  <= wb_fire;
         if (cur_load) begin
            cur_op <= cur_next;
         end
         if (wb_fire) begin
            wb_rd   <= cur_op.rd;
            wb_data <= lsu_rdata;
            wb_slot <= cur_op.slot;
         end
      end
   end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed self-checking bench for lsu_arbiter.
module tb_lsu_arbiter;

   logic        clk = 1'b0;
   logic        rst, req1, req2, we1, we2, flush, lsu_done;
   logic [2:0]  f3_1, f3_2;
   logic [31:0] addr1, addr2, wdata1, wdata2, lsu_rdata;
   logic [4:0]  rd1, rd2;
   logic        accept1, accept2, stall, lsu_start, lsu_we, wb_valid, wb_slot;
   logic [31:0] lsu_addr, lsu_wdata, wb_data;
   logic [2:0]  lsu_f3;
   logic [4:0]  wb_rd;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   lsu_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .req1      (req1),
      .req2      (req2),
      .we1       (we1),
      .we2       (we2),
      .f3_1      (f3_1),
      .f3_2      (f3_2),
      .addr1     (addr1),
      .addr2     (addr2),
      .wdata1    (wdata1),
      .wdata2    (wdata2),
      .rd1       (rd1),
      .rd2       (rd2),
      .flush     (flush),
      .lsu_done  (lsu_done),
      .lsu_rdata (lsu_rdata),
      .accept1   (accept1),
      .accept2   (accept2),
      .stall     (stall),
      .lsu_start (lsu_start),
      .lsu_addr  (lsu_addr),
      .lsu_wdata (lsu_wdata),
      .lsu_we    (lsu_we),
      .lsu_f3    (lsu_f3),
      .wb_valid  (wb_valid),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .wb_slot   (wb_slot)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 2 time units after the edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic all_zero(input string tag);
      chk({tag, ".stall"},     {31'd0, stall},     32'd0);
      chk({tag, ".lsu_start"}, {31'd0, lsu_start}, 32'd0);
      chk({tag, ".lsu_we"},    {31'd0, lsu_we},    32'd0);
      chk({tag, ".lsu_addr"},  lsu_addr,           32'd0);
      chk({tag, ".lsu_wdata"}, lsu_wdata,          32'd0);
      chk({tag, ".lsu_f3"},    {29'd0, lsu_f3},    32'd0);
      chk({tag, ".wb_valid"},  {31'd0, wb_valid},  32'd0);
      chk({tag, ".wb_rd"},     {27'd0, wb_rd},     32'd0);
      chk({tag, ".wb_data"},   wb_data,            32'd0);
      chk({tag, ".wb_slot"},   {31'd0, wb_slot},   32'd0);
   endtask

   task automatic set1(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
      req1 = 1'b1; we1 = we; f3_1 = f3; addr1 = a; wdata1 = wd; rd1 = rd;
   endtask

   task automatic set2(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
      req2 = 1'b1; we2 = we; f3_2 = f3; addr2 = a; wdata2 = wd; rd2 = rd;
   endtask

   initial begin
      rst = 1'b1; req1 = 1'b0; req2 = 1'b0; we1 = 1'b0; we2 = 1'b0; flush = 1'b0;
      lsu_done = 1'b0; f3_1 = '0; f3_2 = '0; addr1 = '0; addr2 = '0;
      wdata1 = '0; wdata2 = '0; rd1 = '0; rd2 = '0; lsu_rdata = '0;

      // Reset state
      tick(); tick();
      rst = 1'b0;
      all_zero("reset");
      #1 chk("reset.accept1_noreq", {31'd0, accept1}, 32'd0);

      // Single load, done three cycles after start
      set1(1'b0, 3'd2, 32'h100, 32'h0, 5'd5);
      #1;
      chk("t1.accept1", {31'd0, accept1}, 32'd1);
      chk("t1.accept2", {31'd0, accept2}, 32'd0);
      tick();
      req1 = 1'b0;
      chk("t1.start",    {31'd0, lsu_start}, 32'd1);
      chk("t1.addr",     lsu_addr,           32'h100);
      chk("t1.we",       {31'd0, lsu_we},    32'd0);
      chk("t1.f3",       {29'd0, lsu_f3},    32'd2);
      chk("t1.stall",    {31'd0, stall},     32'd1);
      tick();
      chk("t1.start_off", {31'd0, lsu_start}, 32'd0);
      tick();
      chk("t1.addr_hold", lsu_addr,           32'h100);
      chk("t1.no_wb",     {31'd0, wb_valid},  32'd0);
      tick();
      lsu_done = 1'b1; lsu_rdata = 32'hDEADBEEF;
      tick();
      lsu_done = 1'b0;
      chk("t1.wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("t1.wb_rd",    {27'd0, wb_rd},    32'd5);
      chk("t1.wb_data",  wb_data,           32'hDEADBEEF);
      chk("t1.wb_slot",  {31'd0, wb_slot},  32'd0);
      chk("t1.stall_off", {31'd0, stall},   32'd0);
      tick();
      chk("t1.wb_pulse", {31'd0, wb_valid}, 32'd0);

      // Dual request: slot1 store then slot2 load
      set1(1'b1, 3'd2, 32'h200, 32'h11, 5'd0);
      set2(1'b0, 3'd4, 32'h204, 32'h0, 5'd7);
      #1;
      chk("t2.accept1", {31'd0, accept1}, 32'd1);
      chk("t2.accept2", {31'd0, accept2}, 32'd1);
      tick();
      req1 = 1'b0; req2 = 1'b0;
      chk("t2.start1", {31'd0, lsu_start}, 32'd1);
      chk("t2.we1",    {31'd0, lsu_we},    32'd1);
      chk("t2.addr1",  lsu_addr,           32'h200);
      chk("t2.wdata1", lsu_wdata,          32'h11);
      chk("t2.stall1", {31'd0, stall},     32'd1);
      tick();
      lsu_done = 1'b1; lsu_rdata = 32'h12345678;
      tick();
      lsu_done = 1'b0;
      chk("t2.store_no_wb", {31'd0, wb_valid}, 32'd0);
      chk("t2.start2", {31'd0, lsu_start}, 32'd1);
      chk("t2.addr2",  lsu_addr,           32'h204);
      chk("t2.we2",    {31'd0, lsu_we},    32'd0);
      chk("t2.f3_2",   {29'd0, lsu_f3},    32'd4);
      chk("t2.stall2", {31'd0, stall},     32'd1);
      tick();
      chk("t2.stall3", {31'd0, stall},     32'd1);
      lsu_done = 1'b1; lsu_rdata = 32'hCAFEF00D;
      tick();
      lsu_done = 1'b0;
      chk("t2.wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("t2.wb_rd",    {27'd0, wb_rd},    32'd7);
      chk("t2.wb_slot",  {31'd0, wb_slot},  32'd1);
      chk("t2.wb_data",  wb_data,           32'hCAFEF00D);
      chk("t2.stall_off", {31'd0, stall},   32'd0);

      // Dual request, flush during slot1 WAIT
      set1(1'b0, 3'd2, 32'h300, 32'h0, 5'd3);
      set2(1'b0, 3'd2, 32'h304, 32'h0, 5'd4);
      tick();
      req1 = 1'b0; req2 = 1'b0;
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t3.stall_wait", {31'd0, stall}, 32'd1);
      lsu_done = 1'b1; lsu_rdata = 32'h33;
      tick();
      lsu_done = 1'b0;
      chk("t3.wb_valid",  {31'd0, wb_valid},  32'd1);
      chk("t3.wb_rd",     {27'd0, wb_rd},     32'd3);
      chk("t3.no_start2", {31'd0, lsu_start}, 32'd0);
      chk("t3.stall_off", {31'd0, stall},     32'd0);
      tick();
      chk("t3.no_start2b", {31'd0, lsu_start}, 32'd0);
      chk("t3.addr_kept",  lsu_addr,           32'h300);

      // Flush coincident with done while an op is pending
      set1(1'b0, 3'd2, 32'h400, 32'h0, 5'd8);
      set2(1'b1, 3'd2, 32'h404, 32'h99, 5'd0);
      tick();
      req1 = 1'b0; req2 = 1'b0;
      tick();
      flush = 1'b1; lsu_done = 1'b1; lsu_rdata = 32'h44;
      tick();
      flush = 1'b0; lsu_done = 1'b0;
      chk("t4.wb_rd",     {27'd0, wb_rd},     32'd8);
      chk("t4.no_start",  {31'd0, lsu_start}, 32'd0);
      chk("t4.stall_off", {31'd0, stall},     32'd0);
      tick();
      chk("t4.no_start2", {31'd0, lsu_start}, 32'd0);

      // Flush in IDLE blocks acceptance
      set1(1'b0, 3'd2, 32'h480, 32'h0, 5'd1);
      flush = 1'b1;
      #1 chk("t4.idle_flush_acc", {31'd0, accept1}, 32'd0);
      tick();
      req1 = 1'b0; flush = 1'b0;
      chk("t4.idle_flush_start", {31'd0, lsu_start}, 32'd0);
      chk("t4.idle_flush_stall", {31'd0, stall},     32'd0);

      // Reset in WAIT, then a stray done
      set1(1'b0, 3'd5, 32'h500, 32'h0, 5'd9);
      tick();
      req1 = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      all_zero("t5");
      lsu_done = 1'b1; lsu_rdata = 32'h55;
      tick();
      lsu_done = 1'b0;
      chk("t5.stray_wb",    {31'd0, wb_valid}, 32'd0);
      chk("t5.stray_data",  wb_data,           32'd0);
      chk("t5.stray_stall", {31'd0, stall},    32'd0);

      // Request held during a busy period is accepted once IDLE
      set1(1'b0, 3'd2, 32'h600, 32'h0, 5'd10);
      tick();
      set1(1'b0, 3'd1, 32'h700, 32'h0, 5'd11);
      #1 chk("t6.acc_start", {31'd0, accept1}, 32'd0);
      tick();
      chk("t6.acc_wait", {31'd0, accept1}, 32'd0);
      lsu_done = 1'b1; lsu_rdata = 32'h66;
      #1 chk("t6.acc_done", {31'd0, accept1}, 32'd0);
      tick();
      lsu_done = 1'b0;
      chk("t6.wb_rd",   {27'd0, wb_rd},    32'd10);
      chk("t6.acc_idle", {31'd0, accept1}, 32'd1);
      tick();
      req1 = 1'b0;
      chk("t6.start", {31'd0, lsu_start}, 32'd1);
      chk("t6.addr",  lsu_addr,           32'h700);
      chk("t6.f3",    {29'd0, lsu_f3},    32'd1);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
